// File: rtl/md_pkg.sv
// md_pkg: MDOp encodings, FSM states and the start decode shared with the stall unit.
// Optional MDU_MADD_EN adds the madd/maddu/msub/msubu ops to the start decode.
package md_pkg;
  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MADD  = 4'd7,
    MADDU = 4'd8,
    MSUB  = 4'd9,
    MSUBU = 4'd10
  } md_op_e;
  typedef enum logic {IDLE, RUN} md_state_e;
  function automatic logic is_md_start(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
`else
    return op inside {MULT, MULTU, DIV, DIVU};
`endif
  endfunction
endpackage

// File: rtl/md_datapath.sv
// md_datapath: combinational 64-bit {HI,LO} result for the md op; divide by zero holds HI/LO.
// MDU_MADD_EN enables the accumulate/subtract forms.
module md_datapath
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);
  logic [63:0] hl, smul, umul;
  logic [31:0] bs, sq, sr, uq, ur;
  logic        bz;
  assign hl   = {hi, lo};
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'd0, a} * {32'd0, b};
  // a safe divisor keeps the unused quotient free of X when b is zero
  assign bz   = b == 32'd0;
  assign bs   = bz ? 32'd1 : b;
  assign sq   = $signed(a) / $signed(bs);
  assign sr   = $signed(a) % $signed(bs);
  assign uq   = a / bs;
  assign ur   = a % bs;
  assign res  = op == MULT  ? smul :
                op == MULTU ? umul :
                op == DIV   ? (bz ? hl : {sr, sq}) :
                op == DIVU  ? (bz ? hl : {ur, uq}) :
`ifdef MDU_MADD_EN
                op == MADD  ? hl + smul :
                op == MADDU ? hl + umul :
                op == MSUB  ? hl - smul :
                op == MSUBU ? hl - umul :
`endif
                hl;
endmodule

// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide unit owning HI/LO, with Start/Busy for the stall unit.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);
  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] tmp_hi, tmp_lo;
  logic [63:0] res;
  md_datapath u_dp (.op(MDOp), .a(A), .b(B), .hi(HI), .lo(LO), .res(res));
  assign Busy  = state == RUN;
  assign Start = is_md_start(MDOp) && !Req && !Busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else if (state == IDLE) begin
      if (Start) begin
        state            <= RUN;
        cnt              <= (MDOp == DIV || MDOp == DIVU) ? DIV_N : MULT_N;
        {tmp_hi, tmp_lo} <= res;
      end else if (!Req && MDOp == MTHI) HI <= A;
      else if (!Req && MDOp == MTLO) LO <= A;
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        {HI, LO} <= {tmp_hi, tmp_lo};
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (optionally built with MDU_MADD_EN).
module tb_md_unit;
  import md_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, Req = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        Start, Busy;
  logic [31:0] HI, LO;
  int          n_tests = 0, n_fail = 0;
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B), .Req(Req),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                        input int n, input logic [31:0] old_hi, old_lo, exp_hi, exp_lo);
    MDOp = op; A = a; B = b;
    #1 check({tag, " start"}, Start, 1'b1);
    tick;
    MDOp = NONE;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s busy c%0d", tag, i), Busy, 1'b1);
      check($sformatf("%s hold c%0d", tag, i), {HI, LO}, {old_hi, old_lo});
      tick;
    end
    check({tag, " done"}, Busy, 1'b0);
    check({tag, " hi"}, HI, exp_hi);
    check({tag, " lo"}, LO, exp_lo);
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    check("rst busy", Busy, 1'b0);
    check("rst hilo", {HI, LO}, 64'd0);
    #1 check("rst start", Start, 1'b0);
    run_op("mult", MULT, 32'hFFFFFFFF, 32'h2, 5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", MULTU, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE);
    run_op("div", DIV, 32'hFFFFFFF9, 32'h2, 10, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", DIVU, 32'h5, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divneg", DIV, 32'h7, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h1, 32'hFFFFFFFD);
    run_op("divu", DIVU, 32'h64, 32'h7, 10, 32'h1, 32'hFFFFFFFD, 32'h2, 32'hE);
    // flushed mult has no effect
    Req = 1'b1; MDOp = MULT; A = 32'h3; B = 32'h5;
    #1 check("req start", Start, 1'b0);
    tick;
    check("req busy", Busy, 1'b0);
    check("req hilo", {HI, LO}, {32'h2, 32'hE});
    MDOp = MTHI; A = 32'h12345678;
    tick;
    check("req mthi", HI, 32'h2);
    Req = 1'b0;
    tick;
    check("mthi", HI, 32'h12345678);
    MDOp = MTLO; A = 32'hCAFEF00D;
    tick;
    check("mtlo", LO, 32'hCAFEF00D);
    check("mtlo busy", Busy, 1'b0);
    MDOp = 4'd15;
    #1 check("undef start", Start, 1'b0);
    tick;
    check("undef hilo", {HI, LO}, {32'h12345678, 32'hCAFEF00D});
    // md ops while busy are ignored
    MDOp = MULT; A = 32'h3; B = 32'h5;
    tick;
    MDOp = MTHI; A = 32'h1111;
    #1 check("busy mthi start", Start, 1'b0);
    tick;
    MDOp = DIV; B = 32'h1;
    #1 check("busy div start", Start, 1'b0);
    tick;
    check("busy mthi ignored", HI, 32'h12345678);
    MDOp = NONE;
    tick;
    tick;
    check("busy c5", Busy, 1'b1);
    tick;
    check("busy ignore done", {HI, LO}, {32'h0, 32'hF});
    check("busy ignore idle", Busy, 1'b0);
    // reset aborts an in-flight divide
    MDOp = DIV; A = 32'h64; B = 32'h3;
    tick;
    MDOp = NONE;
    tick;
    tick;
    tick;
    check("abort busy c4", Busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort busy", Busy, 1'b0);
    check("abort hilo", {HI, LO}, 64'd0);
    run_op("post rst mult", MULT, 32'h3, 32'h5, 5, 32'h0, 32'h0, 32'h0, 32'hF);
`ifdef MDU_MADD_EN
    MDOp = MTHI; A = 32'h0;
    tick;
    MDOp = MTLO; A = 32'hFFFFFFFF;
    tick;
    run_op("maddu", MADDU, 32'h1, 32'h1, 5, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    run_op("msub", MSUB, 32'hFFFFFFFF, 32'h1, 5, 32'h1, 32'h0, 32'h1, 32'h1);
`else
    MDOp = MADDU; A = 32'h1; B = 32'h1;
    #1 check("maddu off start", Start, 1'b0);
    tick;
    check("maddu off busy", Busy, 1'b0);
    check("maddu off hilo", {HI, LO}, {32'h0, 32'hF});
    MDOp = NONE;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
